// File: rtl/cdc_fifo_read_pointer.sv
// rtl/cdc_fifo_read_pointer.sv - read-domain pointer and status engine for the gray-pointer dual-clock FIFO
// Keeps an extra wrap bit on both pointers so all 2^ADDRESS_WIDTH entries are usable.
module cdc_fifo_read_pointer #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  input  logic [ADDRESS_WIDTH:0]   almost_empty_threshold,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  output logic                     read_accept,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic                     underflow
);

  localparam int PW = ADDRESS_WIDTH + 1;

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0]                  rbin_q, rbin_d;
  logic [PW-1:0]                  rgray_q, rgray_d;
  logic                           underflow_q, underflow_d;
  logic [PW-1:0]                  wgray_sync;
  logic [PW-1:0]                  wbin;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = write_pointer_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wgray_sync = sync_q[SYNC_STAGES-1];
  assign wbin       = gray_to_bin(wgray_sync);

  // Status uses only registered values; empty compares gray codes directly.
  assign empty        = (rgray_q == wgray_sync);
  assign fill_level   = wbin - rbin_q;
  assign almost_empty = (fill_level <= almost_empty_threshold);
  assign read_accept  = read_enable & ~empty;

  always_comb begin
    rbin_d      = rbin_q + {{ADDRESS_WIDTH{1'b0}}, read_accept};
    rgray_d     = rbin_d ^ (rbin_d >> 1);
    underflow_d = underflow_q | (read_enable & empty);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      rbin_q      <= '0;
      rgray_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      underflow_q <= underflow_d;
    end
  end

  assign read_address      = rbin_q[ADDRESS_WIDTH-1:0];
  assign read_pointer_gray = rgray_q;
  assign underflow         = underflow_q;

endmodule
